atm_authenticator: RTL and testbench
====================================

// Module: atm_authenticator
// PURPOSE
//   Account store and transaction engine for the ATM controller: holds per-account PIN and balance
//   tables and authenticates an account-number/PIN pair. Executes balance, withdraw, deposit,
//   change-PIN and exit requests issued by the ATM menu FSM, one request per op_valid pulse.
// PARAMETERS
//   NUM_ACCOUNTS  10    number of accounts; valid account numbers are 0..NUM_ACCOUNTS-1
//   INIT_BALANCE  500   balance of every account after reset
//   PIN_BASE      1234  reset PIN of account k = PIN_BASE + k (16-bit)
// PORTS
//   clk         in   1   clock, all state updates on rising edge
//   rst         in   1   synchronous active-low reset
//   acc_num     in   4   account number presented by the card
//   pin         in   16  PIN entered by user
//   new_pin     in   16  replacement PIN for CHANGE_PIN
//   amount      in   32  unsigned transaction amount
//   operation   in   3   1=BALANCE 2=WITHDRAW 3=DEPOSIT 4=CHANGE_PIN 5=EXIT, others invalid
//   op_valid    in   1   one-cycle request strobe
//   acc_index   out  4   = acc_num when found, else 0
//   acc_found   out  1   acc_num < NUM_ACCOUNTS
//   acc_auth    out  1   acc_found && pin == PIN table entry of acc_num
//   balance     out  32  balance of acc_index (combinational read of table)
//   op_done     out  1   one-cycle pulse, cycle after accepted op_valid
//   op_success  out  1   result of last request, held until next op_done
// BEHAVIOUR
//   - Reset (rst=0 at clk edge): all balances = INIT_BALANCE, PINs = PIN_BASE+k,
//     op_done=0, op_success=0. Reset mid-request discards the request; no table update.
//   - acc_index/acc_found/acc_auth/balance: combinational, zero latency, from current inputs + tables.
//   - op_valid sampled on clk edge; tables update on that edge; op_done=1 the following cycle
//     (latency 1). op_valid in consecutive cycles = back-to-back requests, each handled.
//   - Request while acc_auth=0: no table change, op_success=0 (EXIT included).
//   - BALANCE: no change, success=1.
//   - WITHDRAW: if amount <= balance, balance -= amount, success=1; else unchanged, success=0.
//     amount=0 succeeds with no change; amount==balance leaves 0.
//   - DEPOSIT: 33-bit sum; if carry, unchanged, success=0 (no wrap); else balance += amount, success=1.
//   - CHANGE_PIN: PIN[acc_index] = new_pin, success=1; acc_auth re-evaluates against new PIN
//     from the next cycle (old pin now fails).
//   - EXIT: no change, success=1. Invalid codes (0,6,7): no change, success=0.
//   - op_success only updates when op_done pulses. Only acc_index entry ever modified.
// TESTING
//   - Reset, acc_num=3 pin=1237 -> acc_found=1 acc_auth=1 acc_index=3 balance=500; pin=1236 -> acc_auth=0.
//   - acc_num=12 any pin -> acc_found=0 acc_auth=0 acc_index=0; op_valid WITHDRAW -> op_done=1 op_success=0.
//   - acct 0 auth, WITHDRAW 200 -> next cycle op_done=1 success=1 balance=300;
//     WITHDRAW 301 -> success=0 balance=300; WITHDRAW 300 -> balance=0.
//   - acct 5 auth, DEPOSIT 250 -> balance=750; DEPOSIT 32'hFFFF_FFFF -> success=0 balance=750;
//     acct 6 still 500.
//   - acct 2 CHANGE_PIN new_pin=16'hBEEF -> success=1; pin=1236 -> acc_auth=0;
//     pin=16'hBEEF -> acc_auth=1; reset -> 1236 authenticates again.
//   - operation=7 -> op_done=1 success=0 no change; WITHDRAW with rst=0 same edge -> balance 500, op_done=0.

Source files
------------

// File: rtl/atm_authenticator_if.sv
// atm_authenticator_if: request/response bundle between the ATM menu FSM and the account store.
//   master drives acc_num, pin, new_pin, amount, operation, op_valid;
//   slave returns acc_index, acc_found, acc_auth, balance, op_done, op_success.
interface atm_authenticator_if;
   logic [3:0]  acc_num;
   logic [15:0] pin;
   logic [15:0] new_pin;
   logic [31:0] amount;
   logic [2:0]  operation;
   logic        op_valid;
   logic [3:0]  acc_index;
   logic        acc_found;
   logic        acc_auth;
   logic [31:0] balance;
   logic        op_done;
   logic        op_success;
   modport master (
      output acc_num, pin, new_pin, amount, operation, op_valid,
      input  acc_index, acc_found, acc_auth, balance, op_done, op_success
   );
   modport slave (
      input  acc_num, pin, new_pin, amount, operation, op_valid,
      output acc_index, acc_found, acc_auth, balance, op_done, op_success
   );
endinterface

// File: rtl/atm_authenticator.sv
// atm_authenticator: per-account PIN/balance store that authenticates a card and executes one menu request per op_valid.
//   clk, rst (sync active-low), bus (slave side of atm_authenticator_if).
module atm_authenticator #(
   parameter int          NUM_ACCOUNTS = 10,
   parameter logic [31:0] INIT_BALANCE = 32'd500,
   parameter logic [15:0] PIN_BASE     = 16'd1234
) (
   input logic clk,
   input logic rst,
   atm_authenticator_if.slave bus
);
   typedef enum logic [2:0] {
      OP_BALANCE = 3'd1,
      OP_WITHDRAW = 3'd2,
      OP_DEPOSIT = 3'd3,
      OP_CHANGE_PIN = 3'd4,
      OP_EXIT = 3'd5
   } op_e;
   logic [31:0] bal_q [NUM_ACCOUNTS];
   logic [31:0] bal_d [NUM_ACCOUNTS];
   logic [15:0] pin_q [NUM_ACCOUNTS];
   logic [15:0] pin_d [NUM_ACCOUNTS];
   logic        op_done_q, op_done_d;
   logic        op_success_q, op_success_d;
   logic        found, auth, ok;
   logic [3:0]  idx;
   logic [32:0] sum;
   always_comb begin
      found = 32'(bus.acc_num) < NUM_ACCOUNTS;
      idx   = found ? bus.acc_num : 4'd0;
      auth  = found && bus.pin == pin_q[idx];
      // carry out of the 33-bit sum rejects the deposit instead of wrapping
      sum   = {1'b0, bal_q[idx]} + {1'b0, bus.amount};
      bal_d = bal_q;
      pin_d = pin_q;
      ok    = 1'b0;
      if (bus.op_valid && auth) begin
         case (bus.operation)
            OP_BALANCE, OP_EXIT: ok = 1'b1;
            OP_WITHDRAW: begin
               ok = bus.amount <= bal_q[idx];
               bal_d[idx] = ok ? bal_q[idx] - bus.amount : bal_q[idx];
            end
            OP_DEPOSIT: begin
               ok = !sum[32];
               bal_d[idx] = ok ? sum[31:0] : bal_q[idx];
            end
            OP_CHANGE_PIN: begin
               ok = 1'b1;
               pin_d[idx] = bus.new_pin;
            end
            default: ok = 1'b0;
         endcase
      end
      op_done_d    = bus.op_valid;
      op_success_d = bus.op_valid ? ok : op_success_q;
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int k = 0; k < NUM_ACCOUNTS; k++) begin
            bal_q[k] <= INIT_BALANCE;
            pin_q[k] <= 16'(PIN_BASE + 16'(k));
         end
         op_done_q    <= 1'b0;
         op_success_q <= 1'b0;
      end else begin
         bal_q        <= bal_d;
         pin_q        <= pin_d;
         op_done_q    <= op_done_d;
         op_success_q <= op_success_d;
      end
   end
   assign bus.acc_found  = found;
   assign bus.acc_index  = idx;
   assign bus.acc_auth   = auth;
   assign bus.balance    = bal_q[idx];
   assign bus.op_done    = op_done_q;
   assign bus.op_success = op_success_q;
endmodule

// File: tb/tb_atm_authenticator.sv
// tb_atm_authenticator: directed checks of authentication, each request type, limits and reset behaviour.
module tb_atm_authenticator;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;
   atm_authenticator_if bus ();
   atm_authenticator dut (.clk(clk), .rst(rst), .bus(bus.slave));
   always #5 clk = ~clk;
   task automatic set_acct(input logic [3:0] a, input logic [15:0] p);
      bus.acc_num = a;
      bus.pin = p;
      #1;
   endtask
   task automatic req(input logic [2:0] op, input logic [31:0] amt);
      bus.operation = op;
      bus.amount = amt;
      bus.op_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.op_valid = 1'b0;
   endtask
   task automatic test_reset;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      checks++; if (bus.op_done !== 1'b0) begin errors++; $display("FAIL rst_done got %0d exp 0", bus.op_done); end
      checks++; if (bus.op_success !== 1'b0) begin errors++; $display("FAIL rst_success got %0d exp 0", bus.op_success); end
      set_acct(4'd3, 16'd1237);
      checks++; if (bus.acc_found !== 1'b1) begin errors++; $display("FAIL a3_found got %0d exp 1", bus.acc_found); end
      checks++; if (bus.acc_auth !== 1'b1) begin errors++; $display("FAIL a3_auth got %0d exp 1", bus.acc_auth); end
      checks++; if (bus.acc_index !== 4'd3) begin errors++; $display("FAIL a3_index got %0d exp 3", bus.acc_index); end
      checks++; if (bus.balance !== 32'd500) begin errors++; $display("FAIL a3_balance got %0d exp 500", bus.balance); end
      set_acct(4'd3, 16'd1236);
      checks++; if (bus.acc_auth !== 1'b0) begin errors++; $display("FAIL a3_badpin got %0d exp 0", bus.acc_auth); end
   endtask
   task automatic test_not_found;
      set_acct(4'd12, 16'd1246);
      checks++; if (bus.acc_found !== 1'b0) begin errors++; $display("FAIL a12_found got %0d exp 0", bus.acc_found); end
      checks++; if (bus.acc_auth !== 1'b0) begin errors++; $display("FAIL a12_auth got %0d exp 0", bus.acc_auth); end
      checks++; if (bus.acc_index !== 4'd0) begin errors++; $display("FAIL a12_index got %0d exp 0", bus.acc_index); end
      req(3'd2, 32'd10);
      checks++; if (bus.op_done !== 1'b1) begin errors++; $display("FAIL a12_done got %0d exp 1", bus.op_done); end
      checks++; if (bus.op_success !== 1'b0) begin errors++; $display("FAIL a12_success got %0d exp 0", bus.op_success); end
      set_acct(4'd0, 16'd1234);
      checks++; if (bus.balance !== 32'd500) begin errors++; $display("FAIL a12_a0_untouched got %0d exp 500", bus.balance); end
   endtask
   task automatic test_withdraw;
      set_acct(4'd0, 16'd1234);
      req(3'd2, 32'd200);
      checks++; if (bus.op_done !== 1'b1) begin errors++; $display("FAIL wd200_done got %0d exp 1", bus.op_done); end
      checks++; if (bus.op_success !== 1'b1) begin errors++; $display("FAIL wd200_success got %0d exp 1", bus.op_success); end
      checks++; if (bus.balance !== 32'd300) begin errors++; $display("FAIL wd200_balance got %0d exp 300", bus.balance); end
      req(3'd2, 32'd301);
      checks++; if (bus.op_success !== 1'b0) begin errors++; $display("FAIL wd301_success got %0d exp 0", bus.op_success); end
      checks++; if (bus.balance !== 32'd300) begin errors++; $display("FAIL wd301_balance got %0d exp 300", bus.balance); end
      req(3'd2, 32'd300);
      checks++; if (bus.op_success !== 1'b1) begin errors++; $display("FAIL wd300_success got %0d exp 1", bus.op_success); end
      checks++; if (bus.balance !== 32'd0) begin errors++; $display("FAIL wd300_balance got %0d exp 0", bus.balance); end
      req(3'd2, 32'd0);
      checks++; if (bus.op_success !== 1'b1) begin errors++; $display("FAIL wd0_success got %0d exp 1", bus.op_success); end
      checks++; if (bus.balance !== 32'd0) begin errors++; $display("FAIL wd0_balance got %0d exp 0", bus.balance); end
   endtask
   task automatic test_deposit;
      set_acct(4'd5, 16'd1239);
      req(3'd3, 32'd250);
      checks++; if (bus.op_success !== 1'b1) begin errors++; $display("FAIL dep250_success got %0d exp 1", bus.op_success); end
      checks++; if (bus.balance !== 32'd750) begin errors++; $display("FAIL dep250_balance got %0d exp 750", bus.balance); end
      req(3'd3, 32'hFFFF_FFFF);
      checks++; if (bus.op_success !== 1'b0) begin errors++; $display("FAIL depovf_success got %0d exp 0", bus.op_success); end
      checks++; if (bus.balance !== 32'd750) begin errors++; $display("FAIL depovf_balance got %0d exp 750", bus.balance); end
      set_acct(4'd6, 16'd1240);
      checks++; if (bus.balance !== 32'd500) begin errors++; $display("FAIL dep_a6_balance got %0d exp 500", bus.balance); end
   endtask
   task automatic test_change_pin;
      set_acct(4'd2, 16'd1236);
      bus.new_pin = 16'hBEEF;
      req(3'd4, 32'd0);
      checks++; if (bus.op_success !== 1'b1) begin errors++; $display("FAIL cp_success got %0d exp 1", bus.op_success); end
      checks++; if (bus.acc_auth !== 1'b0) begin errors++; $display("FAIL cp_oldpin got %0d exp 0", bus.acc_auth); end
      set_acct(4'd2, 16'hBEEF);
      checks++; if (bus.acc_auth !== 1'b1) begin errors++; $display("FAIL cp_newpin got %0d exp 1", bus.acc_auth); end
      set_acct(4'd3, 16'd1237);
      checks++; if (bus.acc_auth !== 1'b1) begin errors++; $display("FAIL cp_a3_pin got %0d exp 1", bus.acc_auth); end
   endtask
   task automatic test_ops;
      set_acct(4'd6, 16'd1240);
      req(3'd7, 32'd100);
      checks++; if (bus.op_done !== 1'b1) begin errors++; $display("FAIL op7_done got %0d exp 1", bus.op_done); end
      checks++; if (bus.op_success !== 1'b0) begin errors++; $display("FAIL op7_success got %0d exp 0", bus.op_success); end
      checks++; if (bus.balance !== 32'd500) begin errors++; $display("FAIL op7_balance got %0d exp 500", bus.balance); end
      req(3'd1, 32'd100);
      checks++; if (bus.op_success !== 1'b1) begin errors++; $display("FAIL bal_success got %0d exp 1", bus.op_success); end
      req(3'd0, 32'd100);
      checks++; if (bus.op_success !== 1'b0) begin errors++; $display("FAIL op0_success got %0d exp 0", bus.op_success); end
      req(3'd5, 32'd0);
      checks++; if (bus.op_success !== 1'b1) begin errors++; $display("FAIL exit_success got %0d exp 1", bus.op_success); end
      set_acct(4'd6, 16'd9999);
      req(3'd5, 32'd0);
      checks++; if (bus.op_success !== 1'b0) begin errors++; $display("FAIL exit_unauth got %0d exp 0", bus.op_success); end
      req(3'd3, 32'd5);
      checks++; if (bus.balance !== 32'd500) begin errors++; $display("FAIL dep_unauth_balance got %0d exp 500", bus.balance); end
   endtask
   task automatic test_back_to_back;
      set_acct(4'd6, 16'd1240);
      bus.operation = 3'd2;
      bus.amount = 32'd100;
      bus.op_valid = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (bus.op_done !== 1'b1) begin errors++; $display("FAIL b2b1_done got %0d exp 1", bus.op_done); end
      checks++; if (bus.balance !== 32'd400) begin errors++; $display("FAIL b2b1_balance got %0d exp 400", bus.balance); end
      @(posedge clk);
      #1;
      bus.op_valid = 1'b0;
      checks++; if (bus.op_done !== 1'b1) begin errors++; $display("FAIL b2b2_done got %0d exp 1", bus.op_done); end
      checks++; if (bus.balance !== 32'd300) begin errors++; $display("FAIL b2b2_balance got %0d exp 300", bus.balance); end
      @(posedge clk);
      #1;
      checks++; if (bus.op_done !== 1'b0) begin errors++; $display("FAIL idle_done got %0d exp 0", bus.op_done); end
      checks++; if (bus.op_success !== 1'b1) begin errors++; $display("FAIL idle_hold1 got %0d exp 1", bus.op_success); end
      req(3'd2, 32'd1000);
      checks++; if (bus.op_success !== 1'b0) begin errors++; $display("FAIL wd1000_success got %0d exp 0", bus.op_success); end
      @(posedge clk);
      #1;
      checks++; if (bus.op_success !== 1'b0) begin errors++; $display("FAIL idle_hold0 got %0d exp 0", bus.op_success); end
   endtask
   task automatic test_reset_mid;
      set_acct(4'd6, 16'd1240);
      bus.operation = 3'd2;
      bus.amount = 32'd100;
      bus.op_valid = 1'b1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      bus.op_valid = 1'b0;
      rst = 1'b1;
      checks++; if (bus.op_done !== 1'b0) begin errors++; $display("FAIL rstmid_done got %0d exp 0", bus.op_done); end
      checks++; if (bus.balance !== 32'd500) begin errors++; $display("FAIL rstmid_balance got %0d exp 500", bus.balance); end
      set_acct(4'd0, 16'd1234);
      checks++; if (bus.balance !== 32'd500) begin errors++; $display("FAIL rstmid_a0 got %0d exp 500", bus.balance); end
      set_acct(4'd2, 16'd1236);
      checks++; if (bus.acc_auth !== 1'b1) begin errors++; $display("FAIL rstmid_pin_restored got %0d exp 1", bus.acc_auth); end
      set_acct(4'd2, 16'hBEEF);
      checks++; if (bus.acc_auth !== 1'b0) begin errors++; $display("FAIL rstmid_beef got %0d exp 0", bus.acc_auth); end
   endtask
   initial begin
      bus.acc_num = 4'd0;
      bus.pin = 16'd0;
      bus.new_pin = 16'd0;
      bus.amount = 32'd0;
      bus.operation = 3'd0;
      bus.op_valid = 1'b0;
      test_reset;
      test_not_found;
      test_withdraw;
      test_deposit;
      test_change_pin;
      test_ops;
      test_back_to_back;
      test_reset_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
